// File: rtl/cpu_mode_pkg.sv
// Shared CPU mode definitions for the banked stack-pointer logic.
// Contents: 5-bit CPSR M-field mode constants, the bank index type, the
// switch FSM state type and mode_to_bank(), which maps a mode to its SP bank.
package cpu_mode_pkg;

  localparam logic [4:0] MODE_USR = 5'h10;
  localparam logic [4:0] MODE_FIQ = 5'h11;
  localparam logic [4:0] MODE_IRQ = 5'h12;
  localparam logic [4:0] MODE_SVC = 5'h13;
  localparam logic [4:0] MODE_MON = 5'h16;
  localparam logic [4:0] MODE_ABT = 5'h17;
  localparam logic [4:0] MODE_HYP = 5'h1A;
  localparam logic [4:0] MODE_UND = 5'h1B;
  localparam logic [4:0] MODE_SYS = 5'h1F;

  typedef logic [2:0] bank_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } sw_state_t;

  // Returns {valid, bank index}. usr and sys share bank 0.
  function automatic logic [3:0] mode_to_bank(input logic [4:0] m);
    logic [3:0] r;
    r = 4'b0000;
    if (m[4]) begin
      case (m[3:0])
        4'h0, 4'hF: r = {1'b1, 3'd0};
        4'h1:       r = {1'b1, 3'd1};
        4'h2:       r = {1'b1, 3'd2};
        4'h3:       r = {1'b1, 3'd3};
        4'h6:       r = {1'b1, 3'd4};
        4'h7:       r = {1'b1, 3'd5};
        4'hA:       r = {1'b1, 3'd6};
        4'hB:       r = {1'b1, 3'd7};
        default:    r = 4'b0000;
      endcase
    end
    return r;
  endfunction

  // Bank index only; callers use it for modes already known to be mapped.
  function automatic bank_idx_t mode_bank_idx(input logic [4:0] m);
    logic [3:0] r;
    r = mode_to_bank(m);
    return r[2:0];
  endfunction

endpackage

// File: rtl/sp_bank_rf.sv
// Banked SP register file.
// Ports: clk, rst (async, active-high, loads SP_RESET into every entry);
//   we/waddr/wdata  - synchronous write port
//   raddr_a/rdata_a - asynchronous read used by the switch FSM
//   raddr_b/rdata_b - asynchronous read used by the debug port
module sp_bank_rf
  import cpu_mode_pkg::*;
#(
  parameter int             DW        = 32,
  parameter int             NUM_BANKS = 8,
  parameter logic [DW-1:0]  SP_RESET  = 'h20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  bank_idx_t      waddr,
  input  logic [DW-1:0]  wdata,
  input  bank_idx_t      raddr_a,
  output logic [DW-1:0]  rdata_a,
  input  bank_idx_t      raddr_b,
  output logic [DW-1:0]  rdata_b
);

  logic [DW-1:0] mem_q [NUM_BANKS];

  // Per-entry flops so every entry can take the asynchronous reset value.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_q[gi] <= SP_RESET;
      end else if (we && (waddr == bank_idx_t'(gi))) begin
        mem_q[gi] <= wdata;
      end
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/banked_sp_ctrl.sv
// Banked stack-pointer controller.
// Holds the active SP plus one saved SP per processor mode bank and performs
// mode-switch save/restore through an IDLE/SAVE/LOAD/DONE FSM.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   sw_req/sw_mode         - switch request and target mode (IDLE only)
//   sw_ack, busy           - one-cycle completion pulse, FSM not idle
//   sp_dec/sp_inc          - push/pop step of 2^ALIGN
//   sp_we/sp_wdata         - direct active-SP write (low ALIGN bits cleared)
//   sp, cur_mode           - active SP and the mode owning it
//   rd_bank/rd_data        - combinational debug read of a bank entry
//   mode_err/stk_err       - sticky error flags, cleared by err_clr
module banked_sp_ctrl
  import cpu_mode_pkg::*;
#(
  parameter int             DW        = 32,
  parameter int             NUM_BANKS = 8,
  parameter logic [DW-1:0]  SP_RESET  = 'h20,
  parameter int             ALIGN     = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sw_req,
  input  logic [4:0]     sw_mode,
  output logic           sw_ack,
  output logic           busy,
  input  logic           sp_dec,
  input  logic           sp_inc,
  input  logic           sp_we,
  input  logic [DW-1:0]  sp_wdata,
  output logic [DW-1:0]  sp,
  output logic [4:0]     cur_mode,
  input  logic [2:0]     rd_bank,
  output logic [DW-1:0]  rd_data,
  output logic           mode_err,
  input  logic           err_clr,
  output logic           stk_err
);

  localparam logic [DW-1:0] STEP       = DW'(1) << ALIGN;
  localparam logic [DW-1:0] ALIGN_MASK = ~(STEP - DW'(1));
  localparam logic [DW-1:0] INC_LIMIT  = {DW{1'b1}} - STEP;

  sw_state_t     state_q, state_d;
  logic [DW-1:0] sp_q, sp_d;
  logic [4:0]    cur_mode_q, cur_mode_d;
  logic [4:0]    tgt_mode_q, tgt_mode_d;
  bank_idx_t     tgt_bank_q, tgt_bank_d;
  logic          mode_err_q, mode_err_d;
  logic          stk_err_q, stk_err_d;

  logic [3:0]    sw_map;
  bank_idx_t     cur_bank;
  logic          rf_we;
  logic [DW-1:0] rf_rdata_a;

  assign sw_map   = mode_to_bank(sw_mode);
  assign cur_bank = mode_bank_idx(cur_mode_q);

  sp_bank_rf #(
    .DW        (DW),
    .NUM_BANKS (NUM_BANKS),
    .SP_RESET  (SP_RESET)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (cur_bank),
    .wdata   (sp_q),
    .raddr_a (tgt_bank_q),
    .rdata_a (rf_rdata_a),
    .raddr_b (rd_bank),
    .rdata_b (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    cur_mode_d = cur_mode_q;
    tgt_mode_d = tgt_mode_q;
    tgt_bank_d = tgt_bank_q;
    // Clear first so a new error in the same cycle wins.
    mode_err_d = err_clr ? 1'b0 : mode_err_q;
    stk_err_d  = err_clr ? 1'b0 : stk_err_q;
    rf_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sp_we) begin
          sp_d = sp_wdata & ALIGN_MASK;
        end else if (sp_dec && sp_inc) begin
          sp_d = sp_q;
        end else if (sp_dec) begin
          if (sp_q < STEP) stk_err_d = 1'b1;
          else             sp_d = sp_q - STEP;
        end else if (sp_inc) begin
          if (sp_q > INC_LIMIT) stk_err_d = 1'b1;
          else                  sp_d = sp_q + STEP;
        end

        if (sw_req) begin
          if (!sw_map[3]) begin
            mode_err_d = 1'b1;
            state_d    = ST_DONE;
          end else if (sw_map[2:0] == cur_bank) begin
            cur_mode_d = sw_mode;
            state_d    = ST_DONE;
          end else begin
            tgt_mode_d = sw_mode;
            tgt_bank_d = sw_map[2:0];
            state_d    = ST_SAVE;
          end
        end
      end
      ST_SAVE: begin
        // sp_q already includes any same-cycle update made with the request.
        rf_we   = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sp_d       = rf_rdata_a;
        cur_mode_d = tgt_mode_q;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sp_q       <= SP_RESET;
      cur_mode_q <= MODE_SYS;
      tgt_mode_q <= MODE_SYS;
      tgt_bank_q <= '0;
      mode_err_q <= 1'b0;
      stk_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      cur_mode_q <= cur_mode_d;
      tgt_mode_q <= tgt_mode_d;
      tgt_bank_q <= tgt_bank_d;
      mode_err_q <= mode_err_d;
      stk_err_q  <= stk_err_d;
    end
  end

  assign sp       = sp_q;
  assign cur_mode = cur_mode_q;
  assign sw_ack   = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);
  assign mode_err = mode_err_q;
  assign stk_err  = stk_err_q;

endmodule

// File: tb/tb_banked_sp_ctrl.sv
// Directed bench for banked_sp_ctrl with hand-computed expected values.
module tb_banked_sp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw_req;
  logic [4:0]  sw_mode;
  logic        sw_ack;
  logic        busy;
  logic        sp_dec;
  logic        sp_inc;
  logic        sp_we;
  logic [31:0] sp_wdata;
  logic [31:0] sp;
  logic [4:0]  cur_mode;
  logic [2:0]  rd_bank;
  logic [31:0] rd_data;
  logic        mode_err;
  logic        err_clr;
  logic        stk_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  banked_sp_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .sw_req   (sw_req),
    .sw_mode  (sw_mode),
    .sw_ack   (sw_ack),
    .busy     (busy),
    .sp_dec   (sp_dec),
    .sp_inc   (sp_inc),
    .sp_we    (sp_we),
    .sp_wdata (sp_wdata),
    .sp       (sp),
    .cur_mode (cur_mode),
    .rd_bank  (rd_bank),
    .rd_data  (rd_data),
    .mode_err (mode_err),
    .err_clr  (err_clr),
    .stk_err  (stk_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sw_req = 0; sp_dec = 0; sp_inc = 0; sp_we = 0; err_clr = 0;
  endtask

  initial begin
    rst = 1; sw_mode = 5'h1F; sp_wdata = '0; rd_bank = 0;
    idle_inputs();

    // 1. reset state
    repeat (2) tick();
    chk("rst_sp", sp, 32'h20);
    chk("rst_mode", {27'd0, cur_mode}, 32'h1F);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ack", {31'd0, sw_ack}, 0);
    chk("rst_errs", {30'd0, mode_err, stk_err}, 0);
    for (int b = 0; b < 8; b++) begin
      rd_bank = 3'(b);
      #1;
      chk($sformatf("rst_bank%0d", b), rd_data, 32'h20);
    end
    rst = 0;
    tick();

    // 2. two pushes, then full switch to irq and back to sys
    sp_dec = 1; tick(); tick(); sp_dec = 0;
    chk("push2_sp", sp, 32'h18);
    sw_req = 1; sw_mode = 5'h12; tick(); sw_req = 0;
    chk("irq_c1_busy", {31'd0, busy}, 1);
    chk("irq_c1_ack", {31'd0, sw_ack}, 0);
    tick();
    chk("irq_c2_ack", {31'd0, sw_ack}, 0);
    tick();
    chk("irq_c3_ack", {31'd0, sw_ack}, 1);
    chk("irq_sp", sp, 32'h20);
    chk("irq_mode", {27'd0, cur_mode}, 32'h12);
    rd_bank = 0; #1;
    chk("irq_bank0", rd_data, 32'h18);
    tick();
    chk("irq_c4_ack", {31'd0, sw_ack}, 0);
    chk("irq_c4_busy", {31'd0, busy}, 0);
    sw_req = 1; sw_mode = 5'h1F; tick(); sw_req = 0; tick(); tick();
    chk("sys_ack", {31'd0, sw_ack}, 1);
    chk("sys_sp", sp, 32'h18);
    chk("sys_mode", {27'd0, cur_mode}, 32'h1F);
    rd_bank = 2; #1;
    chk("sys_bank2", rd_data, 32'h20);
    tick();

    // 3. aligned write, simultaneous push/pop
    sp_we = 1; sp_wdata = 32'h1003; tick(); sp_we = 0;
    chk("we_align", sp, 32'h1000);
    sp_dec = 1; sp_inc = 1; tick(); sp_dec = 0; sp_inc = 0;
    chk("decinc_hold", sp, 32'h1000);

    // 4. wrap detection at both ends
    sp_we = 1; sp_wdata = 32'h0; tick(); sp_we = 0;
    sp_dec = 1; tick(); sp_dec = 0;
    chk("underflow_err", {31'd0, stk_err}, 1);
    chk("underflow_sp", sp, 32'h0);
    err_clr = 1; tick(); err_clr = 0;
    chk("errclr_stk", {31'd0, stk_err}, 0);
    sp_we = 1; sp_wdata = 32'hFFFF_FFFC; tick(); sp_we = 0;
    sp_inc = 1; tick(); sp_inc = 0;
    chk("overflow_err", {31'd0, stk_err}, 1);
    chk("overflow_sp", sp, 32'hFFFF_FFFC);
    // clear and new error in the same cycle: set wins
    err_clr = 1; sp_inc = 1; tick(); err_clr = 0; sp_inc = 0;
    chk("clr_vs_set", {31'd0, stk_err}, 1);
    err_clr = 1; tick(); err_clr = 0;
    chk("errclr_stk2", {31'd0, stk_err}, 0);

    // 5. unmapped modes, then same-bank switch sys->usr
    sw_req = 1; sw_mode = 5'h05; tick(); sw_req = 0;
    chk("unmap_ack", {31'd0, sw_ack}, 1);
    chk("unmap_err", {31'd0, mode_err}, 1);
    chk("unmap_sp", sp, 32'hFFFF_FFFC);
    chk("unmap_mode", {27'd0, cur_mode}, 32'h1F);
    tick();
    chk("unmap_ack_off", {31'd0, sw_ack}, 0);
    sw_req = 1; sw_mode = 5'h0F; tick(); sw_req = 0;
    chk("unmap0f_err", {31'd0, mode_err}, 1);
    chk("unmap0f_mode", {27'd0, cur_mode}, 32'h1F);
    tick();
    err_clr = 1; tick(); err_clr = 0;
    chk("errclr_mode", {31'd0, mode_err}, 0);
    sw_req = 1; sw_mode = 5'h10; tick(); sw_req = 0;
    chk("same_ack_c1", {31'd0, sw_ack}, 1);
    chk("same_mode", {27'd0, cur_mode}, 32'h10);
    chk("same_sp", sp, 32'hFFFF_FFFC);
    tick();
    chk("same_ack_off", {31'd0, sw_ack}, 0);

    // 6. reset during LOAD of a svc switch
    sw_req = 1; sw_mode = 5'h13; tick(); sw_req = 0; tick();
    chk("svc_in_load", {31'd0, busy}, 1);
    #2 rst = 1; #1;
    chk("abort_sp", sp, 32'h20);
    chk("abort_mode", {27'd0, cur_mode}, 32'h1F);
    chk("abort_busy", {31'd0, busy}, 0);
    rd_bank = 0; #1;
    chk("abort_bank0", rd_data, 32'h20);
    tick(); rst = 0; tick();

    // sw_req held during SAVE/LOAD is ignored
    sw_req = 1; sw_mode = 5'h13; tick();
    sw_mode = 5'h12; tick(); sw_req = 0; tick();
    chk("ign_ack", {31'd0, sw_ack}, 1);
    chk("ign_mode", {27'd0, cur_mode}, 32'h13);
    chk("ign_sp", sp, 32'h20);
    tick();
    chk("ign_ack_off", {31'd0, sw_ack}, 0);
    tick();
    chk("ign_no_2nd_ack", {31'd0, sw_ack}, 0);
    chk("ign_idle", {31'd0, busy}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
